// File: rtl/heart_pkg.sv
// Shared types and screen geometry for the heart-break animation.
// Helper functions clamp sprite columns so positions never wrap around.
package heart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CRACK,
        FALL,
        DONE
    } heart_state_e;

    localparam int SCREEN_W = 1280;
    localparam int SCREEN_H = 720;
    localparam int HALF_W   = 8;
    localparam int HALF_H   = 12;

    // One-bit-wider arithmetic, clamped at 0 or at the given limit.
    function automatic logic [10:0] sat_dec(input logic [10:0] value, input logic [11:0] step);
        return (step > {1'b0, value}) ? 11'd0 : 11'({1'b0, value} - step);
    endfunction

    function automatic logic [10:0] sat_inc(input logic [10:0] value, input logic [11:0] step,
                                            input logic [10:0] limit);
        logic [11:0] sum;
        sum = {1'b0, value} + step;
        return (sum > {1'b0, limit}) ? limit : sum[10:0];
    endfunction

endpackage

// File: rtl/heart_fall_physics.sv
// Vertical motion of the two heart halves: fall speed, clamped y and the floor-reached flag.
// Define HEART_BREAK_GRAVITY_EN to make the fall speed grow by 1 each frame up to MAX_VY.
module heart_fall_physics
    import heart_pkg::*;
#(
    parameter int MAX_VY  = 8,
    parameter int Y_LIMIT = SCREEN_H - HALF_H
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    input  logic [9:0] base_y,
    output logic [9:0] y,
    output logic       limit_hit
);

    localparam int          VY_W  = (MAX_VY > 1) ? $clog2(MAX_VY + 1) : 1;
    localparam logic [10:0] Y_LIM = 11'(Y_LIMIT);
`ifdef HEART_BREAK_GRAVITY_EN
    localparam logic [VY_W-1:0] VY_CAP = VY_W'(MAX_VY);
`endif

    logic [VY_W-1:0] vy;
    logic [10:0]     y_sum;

    // limit_hit covers both exact arrival and overshoot, so the sequencer can leave FALL on this frame
    assign y_sum     = {1'b0, y} + 11'(vy);
    assign limit_hit = (y_sum >= Y_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y  <= '0;
            vy <= '0;
        end else if (load) begin
            y  <= base_y;
            vy <= VY_W'(1);
        end else if (step) begin
            y <= limit_hit ? Y_LIM[9:0] : y_sum[9:0];
`ifdef HEART_BREAK_GRAVITY_EN
            if (vy < VY_CAP) begin
                vy <= vy + 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/heart_break_sequencer.sv
// Breaks a heart sprite into two halves: short cracked pause, then both halves drift apart and fall.
// Optional HEART_BREAK_GRAVITY_EN (see heart_fall_physics) accelerates the fall.
module heart_break_sequencer
    import heart_pkg::*;
#(
    parameter int CRACK_FRAMES = 8,
    parameter int H_STEP       = 1,
    parameter int MAX_VY       = 8,
    parameter int Y_LIMIT      = SCREEN_H - HALF_H,
    parameter int X_LIMIT      = SCREEN_W - HALF_W
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        new_frame_in,
    input  logic        trigger_in,
    input  logic [10:0] base_x_in,
    input  logic [9:0]  base_y_in,
    output logic [10:0] left_x_out,
    output logic [10:0] right_x_out,
    output logic [9:0]  half_y_out,
    output logic        active_out,
    output logic        done_out
);

    localparam int               CNT_W    = (CRACK_FRAMES > 1) ? $clog2(CRACK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRACK_FRAMES - 1);
    localparam logic [10:0]      X_LIM    = 11'(X_LIMIT);
    localparam logic [11:0]      STEP_X   = 12'(H_STEP);
    localparam logic [11:0]      HALF_OFS = 12'(HALF_W);

    heart_state_e     state, state_next;
    logic [CNT_W-1:0] frame_cnt, frame_cnt_next;
    logic [10:0]      left_next, right_next;
    logic             crack_pending, crack_pending_next;
    logic             accept, fall_step, y_limit_hit;

    heart_fall_physics #(
        .MAX_VY  (MAX_VY),
        .Y_LIMIT (Y_LIMIT)
    ) u_physics (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .load      (accept),
        .step      (fall_step),
        .base_y    (base_y_in),
        .y         (half_y_out),
        .limit_hit (y_limit_hit)
    );

    // crack_pending makes the one-pixel crack split happen on the first cycle spent in CRACK
    always_comb begin
        state_next         = state;
        frame_cnt_next     = frame_cnt;
        left_next          = left_x_out;
        right_next         = right_x_out;
        crack_pending_next = 1'b0;
        accept             = 1'b0;
        fall_step          = 1'b0;
        case (state)
            IDLE: begin
                if (trigger_in) begin
                    accept             = 1'b1;
                    left_next          = base_x_in;
                    right_next         = sat_inc(base_x_in, HALF_OFS, X_LIM);
                    frame_cnt_next     = '0;
                    crack_pending_next = 1'b1;
                    state_next         = CRACK;
                end
            end
            CRACK: begin
                if (crack_pending) begin
                    left_next  = sat_dec(left_x_out, 12'd1);
                    right_next = sat_inc(right_x_out, 12'd1, X_LIM);
                end
                if (new_frame_in) begin
                    if (frame_cnt == CNT_LAST) begin
                        state_next = FALL;
                    end else begin
                        frame_cnt_next = frame_cnt + 1'b1;
                    end
                end
            end
            FALL: begin
                if (new_frame_in) begin
                    fall_step  = 1'b1;
                    left_next  = sat_dec(left_x_out, STEP_X);
                    right_next = sat_inc(right_x_out, STEP_X, X_LIM);
                    if (y_limit_hit) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= IDLE;
            frame_cnt     <= '0;
            crack_pending <= 1'b0;
            left_x_out    <= '0;
            right_x_out   <= '0;
            active_out    <= 1'b0;
            done_out      <= 1'b0;
        end else begin
            state         <= state_next;
            frame_cnt     <= frame_cnt_next;
            crack_pending <= crack_pending_next;
            left_x_out    <= left_next;
            right_x_out   <= right_next;
            active_out    <= (state_next == CRACK) || (state_next == FALL);
            done_out      <= (state_next == DONE);
        end
    end

endmodule
